serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_if.sv | 18 +
 rtl/serial_adder.sv | 104 ++++++++++
 2 files changed

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// master drives a request; slave returns status and the registered result.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 64
) ();
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, sub, a, b, input busy, done, sum, cout, ovf);
  modport slave  (input start, sub, a, b, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial add/subtract, one bit per clock LSB first; WIDTH cycles per operation.
// Subtraction is a + ~b + 1, so cout=1 means no borrow.
module serial_adder #(
  parameter int unsigned WIDTH = 64
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             s_bit, c_next;

  // Full adder on the current LSBs of the shifting operand registers
  assign s_bit  = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_next = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.sub}};
          carry_d = bus.sub;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = c_next;
        res_d   = {s_bit, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB
          state_d = DONE;
          cnt_d   = '0;
          sum_d   = {s_bit, res_q[WIDTH-1:1]};
          cout_d  = c_next;
          ovf_d   = carry_q ^ c_next;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule
